// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: LSB-first frames, optional parity, 1-2 stop bits, internal baud divider.
// Line lags the accepting edge by one cycle; tx_ready low while a frame is in flight (or FIFO full with UART_TX_FIFO_EN).
module uart_tx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk_sis,
  input  logic                          rst,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          tx2,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity_mode
      $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         baud_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_BITS-1:0]  shift;
  logic                  par_bit;
  logic                  bit_end;
  logic                  word_avail;
  logic                  load;
  logic [DATA_BITS-1:0]  load_word;
  logic                  line_nx;

`ifdef UART_TX_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH);

  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
      $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [PW:0]          count;
  logic                 push;

  assign tx_ready   = (count < (PW+1)'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign word_avail = (count != '0);
  assign load_word  = mem[rd_ptr];
  assign fifo_count = count;

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk_sis) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk_sis or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
`else
  assign tx_ready   = (state == IDLE);
  assign word_avail = tx_valid && tx_ready;
  assign load_word  = tx_data;
  assign fifo_count = '0;
`endif

  assign bit_end = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign busy    = (state != IDLE);

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (word_avail) begin
          state_nx = START;
          load     = 1'b1;
        end
      end
      START: begin
        if (bit_end) state_nx = DATA;
      end
      DATA: begin
        if (bit_end && bit_cnt == BW'(DATA_BITS - 1)) begin
          state_nx = (PARITY_MODE != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) state_nx = STOP;
      end
      STOP: begin
        if (bit_end && bit_cnt == BW'(STOP_BITS - 1)) begin
          if (word_avail) begin
            state_nx = START;
            load     = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Line level follows the current state, so tx2 lags the state register by one cycle.
  always_comb begin
    line_nx = 1'b1;
    unique case (state)
      START:   line_nx = 1'b0;
      DATA:    line_nx = shift[0];
      PARITY:  line_nx = par_bit;
      default: line_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk_sis or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tx2      <= 1'b1;
    end else begin
      state <= state_nx;
      tx2   <= line_nx;
      if (load) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
        shift    <= load_word;
        par_bit  <= (PARITY_MODE == 2) ? ~^load_word : ^load_word;
      end else if (state != IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
        if (bit_end) begin
          if (state == DATA) begin
            shift <= shift >> 1;
          end
          if (state_nx != state) begin
            bit_cnt <= '0;
          end else if (state == DATA || state == STOP) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule
